// File: rtl/mm_pkg.sv
// mm_pkg: shared widths, operand/accumulator types and sequencer states for the matrix multiplier
package mm_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ACCUM_WIDTH = 2 * DATA_WIDTH;
  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic signed [ACCUM_WIDTH-1:0] accum_t;
  typedef enum logic [2:0] {CLEAR, LOAD, RUN, CAPTURE, DONE} seq_state_t;
endpackage

// File: rtl/dp_operand_buffer.sv
// dp_operand_buffer: VEC_LEN-deep operand pair register file, one write port and one read port, no reset
module dp_operand_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN = 4
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [$clog2(VEC_LEN)-1:0]    wr_idx,
  input  logic signed [DATA_WIDTH-1:0]  wr_a,
  input  logic signed [DATA_WIDTH-1:0]  wr_b,
  input  logic [$clog2(VEC_LEN)-1:0]    rd_idx,
  output logic signed [DATA_WIDTH-1:0]  rd_a,
  output logic signed [DATA_WIDTH-1:0]  rd_b
);
  logic signed [DATA_WIDTH-1:0] mem_a [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] mem_b [VEC_LEN];
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_a[wr_idx] <= wr_a;
      mem_b[wr_idx] <= wr_b;
    end
  end
  assign rd_a = mem_a[rd_idx];
  assign rd_b = mem_b[rd_idx];
endmodule

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: buffers VEC_LEN operand pairs, streams them into a MAC, returns total/err on valid/ready
module dot_product_sequencer #(
  parameter int DATA_WIDTH = mm_pkg::DATA_WIDTH,
  parameter int ACCUM_WIDTH = mm_pkg::ACCUM_WIDTH,
  parameter int VEC_LEN = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_a,
  input  logic signed [DATA_WIDTH-1:0]  in_b,
  output logic                          mac_clr,
  output logic                          mac_running,
  output logic signed [DATA_WIDTH-1:0]  mac_in1,
  output logic signed [DATA_WIDTH-1:0]  mac_in2,
  input  logic signed [ACCUM_WIDTH-1:0] mac_total,
  input  logic                          mac_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACCUM_WIDTH-1:0] out_total,
  output logic                          out_err
);
  import mm_pkg::*;
  localparam int IW = $clog2(VEC_LEN);
  localparam logic [IW-1:0] LAST = IW'(VEC_LEN - 1);
  seq_state_t state;
  logic [IW-1:0] idx;
  logic last;
  logic signed [DATA_WIDTH-1:0] rd_a, rd_b;
  assign last = idx == LAST;
  assign in_ready = state == LOAD;
  assign mac_clr = state == CLEAR;
  assign mac_running = state == RUN;
  assign out_valid = state == DONE;
  assign mac_in1 = mac_running ? rd_a : '0;
  assign mac_in2 = mac_running ? rd_b : '0;
  dp_operand_buffer #(.DATA_WIDTH(DATA_WIDTH), .VEC_LEN(VEC_LEN)) u_buf (
    .clk    (clk),
    .wr_en  (in_valid & in_ready),
    .wr_idx (idx),
    .wr_a   (in_a),
    .wr_b   (in_b),
    .rd_idx (idx),
    .rd_a   (rd_a),
    .rd_b   (rd_b)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx <= '0;
      out_total <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        CLEAR: state <= LOAD;
        LOAD: begin
          if (in_valid) begin
            idx <= last ? '0 : idx + 1'b1;
            if (last) state <= RUN;
          end
        end
        RUN: begin
          idx <= last ? '0 : idx + 1'b1;
          if (last) state <= CAPTURE;
        end
        CAPTURE: begin
          out_total <= mac_total;
          out_err <= mac_err;
          state <= DONE;
        end
        DONE: if (out_ready) state <= CLEAR;
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer: scoreboard bench for dot_product_sequencer driving a behavioural MAC
module tb_dot_product_sequencer;
  import mm_pkg::*;
  typedef struct {
    accum_t total;
    logic   err;
    bit     chk_total;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  data_t in_a = '0;
  data_t in_b = '0;
  logic mac_clr, mac_running;
  data_t mac_in1, mac_in2;
  accum_t mac_total;
  logic mac_err;
  logic out_valid;
  logic out_ready = 1'b1;
  accum_t out_total;
  logic out_err;
  int pass_cnt = 0;
  int total_cnt = 0;
  int clr_cnt = 0;
  exp_t exp_q[$];
  int va[4];
  int vb[4];
  data_t ri1[4];
  data_t ri2[4];
  int mac_nxt;
  always #5 clk = ~clk;
  dot_product_sequencer #(.DATA_WIDTH(DATA_WIDTH), .ACCUM_WIDTH(ACCUM_WIDTH), .VEC_LEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mac_clr     (mac_clr),
    .mac_running (mac_running),
    .mac_in1     (mac_in1),
    .mac_in2     (mac_in2),
    .mac_total   (mac_total),
    .mac_err     (mac_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_total   (out_total),
    .out_err     (out_err)
  );
  assign mac_nxt = int'(mac_total) + int'(mac_in1) * int'(mac_in2);
  always @(posedge clk) begin
    if (rst || mac_clr) begin
      mac_total <= '0;
      mac_err <= 1'b0;
    end else if (mac_running) begin
      mac_total <= accum_t'(mac_nxt);
      if (mac_nxt > 32767 || mac_nxt < -32768) mac_err <= 1'b1;
    end
  end
  always @(posedge clk) clr_cnt <= clr_cnt + (mac_clr ? 1 : 0);
  task automatic load_vec(input bit gaps);
    int s = 0;
    bit e = 0;
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      s += va[i] * vb[i];
      if (s > 32767 || s < -32768) e = 1;
    end
    x.total = accum_t'(s);
    x.err = e;
    x.chk_total = !e;
    exp_q.push_back(x);
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      in_a = data_t'(va[i]);
      in_b = data_t'(vb[i]);
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        total_cnt++;
        $display("FAIL load_timeout: in_ready got %0b expected 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (gaps && i < 3) begin
        in_a = data_t'(8'h55);
        in_b = data_t'(8'h33);
        @(negedge clk);
      end
    end
  endtask
  task automatic collect(output int lat, output int runs);
    lat = 0;
    runs = 0;
    while (!out_valid && lat < 40) begin
      if (mac_running) begin
        if (runs < 4) begin
          ri1[runs] = mac_in1;
          ri2[runs] = mac_in2;
        end
        runs++;
      end
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b expected 0", in_ready); else pass_cnt++;
    total_cnt++; if (mac_clr !== 1'b1) $display("FAIL rst_mac_clr: got %0b expected 1", mac_clr); else pass_cnt++;
    total_cnt++; if (mac_running !== 1'b0) $display("FAIL rst_running: got %0b expected 0", mac_running); else pass_cnt++;
    total_cnt++; if (mac_in1 !== 8'sd0 || mac_in2 !== 8'sd0) $display("FAIL rst_mac_in: got %0d/%0d expected 0/0", mac_in1, mac_in2); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_total !== 16'sd0 || out_err !== 1'b0) $display("FAIL rst_out: got %0d/%0b expected 0/0", out_total, out_err); else pass_cnt++;
    rst = 1'b0;
    total_cnt++; if (mac_clr !== 1'b1) $display("FAIL rst_clear_cycle: mac_clr got %0b expected 1", mac_clr); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1 || mac_clr !== 1'b0) $display("FAIL rst_to_load: in_ready/mac_clr got %0b/%0b expected 1/0", in_ready, mac_clr); else pass_cnt++;
  endtask
  task automatic test_basic;
    int lat, runs;
    exp_t x;
    va = '{1, 2, 3, 4};
    vb = '{5, 6, 7, 8};
    load_vec(1'b0);
    collect(lat, runs);
    x = exp_q.pop_front();
    total_cnt++; if (lat !== 5) $display("FAIL basic_latency: got %0d expected 5", lat); else pass_cnt++;
    total_cnt++; if (runs !== 4) $display("FAIL basic_running_cycles: got %0d expected 4", runs); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (ri1[k] !== data_t'(va[k]) || ri2[k] !== data_t'(vb[k])) $display("FAIL basic_mac_in[%0d]: got %0d/%0d expected %0d/%0d", k, ri1[k], ri2[k], va[k], vb[k]); else pass_cnt++;
    end
    total_cnt++; if (out_total !== x.total) $display("FAIL basic_total: got %0d expected %0d", out_total, x.total); else pass_cnt++;
    total_cnt++; if (out_err !== x.err) $display("FAIL basic_err: got %0b expected %0b", out_err, x.err); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (mac_clr !== 1'b1 || out_valid !== 1'b0) $display("FAIL basic_handshake: mac_clr/out_valid got %0b/%0b expected 1/0", mac_clr, out_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_return: got %0b expected 1", in_ready); else pass_cnt++;
  endtask
  task automatic test_back_to_back;
    int lat, runs, c0;
    exp_t x;
    va = '{1, 2, 3, 4};
    vb = '{5, 6, 7, 8};
    load_vec(1'b0);
    collect(lat, runs);
    x = exp_q.pop_front();
    total_cnt++; if (out_valid !== 1'b1 || out_total !== x.total) $display("FAIL b2b_first_total: got %0d expected %0d", out_total, x.total); else pass_cnt++;
    c0 = clr_cnt;
    va = '{-1, -1, -1, -1};
    vb = '{1, 2, 3, 4};
    load_vec(1'b0);
    collect(lat, runs);
    x = exp_q.pop_front();
    total_cnt++; if (lat !== 5) $display("FAIL b2b_latency: got %0d expected 5", lat); else pass_cnt++;
    total_cnt++; if (out_total !== x.total) $display("FAIL b2b_second_total: got %0d expected %0d", out_total, x.total); else pass_cnt++;
    total_cnt++; if (out_err !== x.err) $display("FAIL b2b_second_err: got %0b expected %0b", out_err, x.err); else pass_cnt++;
    total_cnt++; if (clr_cnt - c0 !== 1) $display("FAIL b2b_clr_pulses: got %0d expected 1", clr_cnt - c0); else pass_cnt++;
    @(negedge clk);
  endtask
  task automatic test_overflow;
    int lat, runs;
    exp_t x;
    va = '{-128, -128, -128, -128};
    vb = '{-128, -128, -128, -128};
    load_vec(1'b0);
    collect(lat, runs);
    x = exp_q.pop_front();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL ovf_neg_valid: got %0b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_err !== x.err) $display("FAIL ovf_neg_err: got %0b expected %0b", out_err, x.err); else pass_cnt++;
    @(negedge clk);
    va = '{127, 127, 127, 127};
    vb = '{127, 127, 127, 127};
    load_vec(1'b0);
    collect(lat, runs);
    x = exp_q.pop_front();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL ovf_pos_valid: got %0b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_err !== x.err) $display("FAIL ovf_pos_err: got %0b expected %0b", out_err, x.err); else pass_cnt++;
    @(negedge clk);
  endtask
  task automatic test_gaps_backpressure;
    int lat, runs;
    exp_t x;
    out_ready = 1'b0;
    va = '{1, 2, 3, 4};
    vb = '{5, 6, 7, 8};
    load_vec(1'b1);
    collect(lat, runs);
    x = exp_q.pop_front();
    total_cnt++; if (out_valid !== 1'b1 || out_total !== x.total) $display("FAIL gaps_total: got %0d expected %0d", out_total, x.total); else pass_cnt++;
    total_cnt++; if (out_err !== x.err) $display("FAIL gaps_err: got %0b expected %0b", out_err, x.err); else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %0b expected 1", c, out_valid); else pass_cnt++;
      total_cnt++; if (out_total !== x.total) $display("FAIL hold_total[%0d]: got %0d expected %0d", c, out_total, x.total); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %0b expected 0", c, in_ready); else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (mac_clr !== 1'b1 || out_valid !== 1'b0) $display("FAIL release_clear: mac_clr/out_valid got %0b/%0b expected 1/0", mac_clr, out_valid); else pass_cnt++;
  endtask
  task automatic test_reset_mid_run;
    int lat, runs;
    exp_t x;
    va = '{1, 2, 3, 4};
    vb = '{5, 6, 7, 8};
    load_vec(1'b0);
    repeat (2) @(negedge clk);
    total_cnt++; if (mac_running !== 1'b1 || mac_in1 !== 8'sd3) $display("FAIL midrun_idx2: running/in1 got %0b/%0d expected 1/3", mac_running, mac_in1); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    total_cnt++; if (mac_running !== 1'b0) $display("FAIL midrun_running: got %0b expected 0", mac_running); else pass_cnt++;
    total_cnt++; if (mac_clr !== 1'b1) $display("FAIL midrun_clr: got %0b expected 1", mac_clr); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrun_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_total !== 16'sd0 || in_ready !== 1'b0) $display("FAIL midrun_out_total_in_ready: got %0d/%0b expected 0/0", out_total, in_ready); else pass_cnt++;
    load_vec(1'b0);
    collect(lat, runs);
    x = exp_q.pop_front();
    total_cnt++; if (out_valid !== 1'b1 || out_total !== x.total) $display("FAIL midrun_reload_total: got %0d expected %0d", out_total, x.total); else pass_cnt++;
    total_cnt++; if (out_err !== x.err) $display("FAIL midrun_reload_err: got %0b expected %0b", out_err, x.err); else pass_cnt++;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_gaps_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Upstream control stage for the `MAC` accumulator in the matrix multiplier datapath. It accepts one row/column operand pair per handshake beat and buffers `VEC_LEN` pairs. It then streams them into `MAC` by driving `in1`/`in2`/`running`/`clr`. It captures the finished `total`/`err` and presents it downstream on a valid/ready handshake. One instance feeds one `MAC`; the array top instantiates one pair per output element.

## Interface
- `DATA_WIDTH`, 8, signed operand width (matches `MAC`).
- `ACCUM_WIDTH`, `2*DATA_WIDTH`, signed accumulator width (matches `MAC`).
- `VEC_LEN`, 4, dot-product length; must be ≥ 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `in_valid`  input  1  operand pair on `in_a`/`in_b` is valid.
- `in_ready`  output  1  sequencer accepts a pair this cycle.
- `in_a`, `in_b`  input  `DATA_WIDTH` each  signed operand pair.
- `mac_clr`  output  1  drives `MAC.clr`.
- `mac_running`  output  1  drives `MAC.running`.
- `mac_in1`, `mac_in2`  output  `DATA_WIDTH` each  drive `MAC.in1`/`MAC.in2`.
- `mac_total`  input  `ACCUM_WIDTH`  from `MAC.total`.
- `mac_err`  input  1  from `MAC.err`, sticky overflow until `clr`.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_total`  output  `ACCUM_WIDTH`  captured dot product.
- `out_err`  output  1  captured overflow flag.

## Operation
- `MAC` contract: `total` is updated at each rising edge where `running`=1. `clr` zeroes `total` and `err` at the rising edge. The top-level drives `MAC.rst_n = ~rst`.
- FSM states are CLEAR, LOAD, RUN, CAPTURE and DONE. All outputs are decoded from the registered state, index and buffers. There are no combinational paths from inputs to outputs.
- **CLEAR:** `mac_clr`=1. Always moves to LOAD after one cycle.
- **LOAD:**
  - `in_ready`=1.
  - Each `in_valid & in_ready` edge writes `buf_a[idx]`/`buf_b[idx]` and increments `idx`.
  - On the write with `idx == VEC_LEN-1`, `idx` goes to 0 and the FSM goes to RUN.
  - Cycles with `in_valid`=0 leave state and buffers unchanged.
- **RUN:**
  - `mac_running`=1, `mac_in1=buf_a[idx]`, `mac_in2=buf_b[idx]`, and `idx` increments every cycle.
  - After `VEC_LEN` cycles, `idx` goes to 0 and the FSM goes to CAPTURE.
- **CAPTURE:** `mac_running`=0. The next edge registers `mac_total`→`out_total` and `mac_err`→`out_err`, then moves to DONE.
- **DONE:** `out_valid`=1. `out_total`/`out_err` stay stable. The FSM stays in DONE while `out_ready`=0 and moves to CLEAR on `out_ready`=1.
- `mac_in1`/`mac_in2` are 0 outside RUN. `in_ready`=0 outside LOAD.
- `idx` is `$clog2(VEC_LEN)` bits wide and never exceeds `VEC_LEN-1`. There is no wrap beyond the buffer.
- No arithmetic is done in this block. Widths pass through unchanged. Overflow detection belongs to `MAC` and is only forwarded.
- Reset, including mid-LOAD, mid-RUN or mid-DONE:
  - State goes to CLEAR, `idx`=0, `out_total`=0, `out_err`=0.
  - Buffer contents are don't-care and never observable.
  - A pending result is dropped.

## Timing
- Reset values: `in_ready`=0, `mac_clr`=1, `mac_running`=0, `mac_in1`/`mac_in2`=0, `out_valid`=0, `out_total`=0, `out_err`=0.
- `mac_clr` is high during reset and for the first cycle after `rst` deasserts. `in_ready` rises the cycle after that.
- Let the last LOAD beat be accepted at edge E:
  - `mac_running` is high for cycles E..E+VEC_LEN-1.
  - `MAC` accumulates at edges E+1..E+VEC_LEN.
  - `out_valid` rises after edge E+VEC_LEN+1.
- On the `out_valid & out_ready` edge, the next cycle is CLEAR. `in_ready` returns one cycle later.
- Minimum period per dot product: `2*VEC_LEN + 3` cycles.

## Structure
- Shared package `mm_pkg`: `DATA_WIDTH`, `ACCUM_WIDTH`, `data_t`, `accum_t`, and the `seq_state_t` enum. `MAC` and the future array top import the same package.
- Natural sub-module `dp_operand_buffer`: `VEC_LEN`-deep pair register file with write enable and write index, and a read index. It contains no reset logic.
- FSM, index counter and output registers live in `dot_product_sequencer`. `MAC` is instantiated outside it.

## Test plan
All scenarios use `VEC_LEN`=4 with a behavioural `MAC` model or a real `MAC` instance.
- **Basic result:** load a={1,2,3,4}, b={5,6,7,8}, `out_ready`=1 → `out_valid` at E+5 with `out_total`=70, `out_err`=0. `mac_running` is high for exactly 4 cycles.
- **Overflow:** load a={-128,-128,-128,-128}, b={-128,-128,-128,-128} → `out_err`=1. Load a={127,127,127,127}, b={127,127,127,127} (sum 64516) → `out_err`=1.
- **Back-to-back with clear:**
  - After the 70 result, load a={-1,-1,-1,-1}, b={1,2,3,4} → `out_total`=-10, `out_err`=0.
  - `mac_clr` pulses exactly one cycle between the two results.
- **Backpressure and gaps:**
  - Toggle `in_valid` every other cycle during LOAD → only valid beats are written, and the result is still 70.
  - Hold `out_ready`=0 for 10 cycles → `out_valid` stays 1, `out_total` stays 70, `in_ready` stays 0.
- **Reset mid-RUN:**
  - Assert `rst` for 1 cycle at RUN `idx`=2 → next cycle `mac_running`=0, `mac_clr`=1, `out_valid`=0.
  - A fresh load of {1,2,3,4}·{5,6,7,8} then yields 70.
